// File: rtl/poly_eval_horner.sv
// Serial-load polynomial evaluator: coefficients and x are entered one slot per go
// press/release, then y is computed by Horner's rule on a single multiply/add datapath.
module poly_eval_horner #(
    parameter int W      = 8,
    parameter int DEGREE = 2,
    parameter int IW     = $clog2(DEGREE + 2)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          go,
    input  logic [W-1:0]  data_in,
    output logic [W-1:0]  data_result,
    output logic          overflow,
    output logic          done,
    output logic          busy,
    output logic [IW-1:0] load_idx
);

    typedef enum logic [2:0] {
        S_LOAD      = 3'd0,
        S_LOAD_WAIT = 3'd1,
        S_INIT      = 3'd2,
        S_MUL       = 3'd3,
        S_ADD       = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [DEGREE:0][W-1:0]  coef_q, coef_d;
    logic [W-1:0]            x_q, x_d;
    logic [W-1:0]            acc_q, acc_d;
    logic [W-1:0]            result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    overflow_q, overflow_d;
    logic                    done_q, done_d;
    logic [IW-1:0]           load_idx_q, load_idx_d;
    logic [IW-1:0]           i_q, i_d;

    logic [W-1:0]            coef_sel;
    logic [2*W-1:0]          prod;
    logic [W:0]              sum;
    logic                    last_slot;

    assign last_slot = (load_idx_q == IW'(DEGREE + 1));

    // Explicit decode keeps the index lookup in range for any IW/DEGREE pairing.
    always_comb begin
        coef_sel = '0;
        for (int k = 0; k <= DEGREE; k++) begin
            if (i_q == IW'(k)) coef_sel = coef_q[k];
        end
    end

    assign prod = {{W{1'b0}}, acc_q} * {{W{1'b0}}, x_q};
    assign sum  = {1'b0, acc_q} + {1'b0, coef_sel};

    always_comb begin
        state_d    = state_q;
        coef_d     = coef_q;
        x_d        = x_q;
        acc_d      = acc_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        load_idx_d = load_idx_q;
        i_d        = i_q;
        case (state_q)
            S_LOAD: begin
                for (int k = 0; k <= DEGREE; k++) begin
                    if (load_idx_q == IW'(k)) coef_d[k] = data_in;
                end
                if (last_slot) x_d = data_in;
                if (go) state_d = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                // Advance only on release so a held go counts once.
                if (!go) begin
                    if (last_slot) begin
                        state_d = S_INIT;
                    end else begin
                        load_idx_d = load_idx_q + IW'(1);
                        state_d    = S_LOAD;
                    end
                end
            end
            S_INIT: begin
                acc_d   = coef_q[DEGREE];
                i_d     = IW'(DEGREE - 1);
                ovf_d   = 1'b0;
                state_d = S_MUL;
            end
            S_MUL: begin
                acc_d   = prod[W-1:0];
                ovf_d   = ovf_q | (|prod[2*W-1:W]);
                state_d = S_ADD;
            end
            S_ADD: begin
                acc_d = sum[W-1:0];
                ovf_d = ovf_q | sum[W];
                if (i_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q - IW'(1);
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                result_d   = acc_q;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                load_idx_d = '0;
                state_d    = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_LOAD;
            coef_q     <= '0;
            x_q        <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            load_idx_q <= '0;
            i_q        <= '0;
        end else begin
            state_q    <= state_d;
            coef_q     <= coef_d;
            x_q        <= x_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            load_idx_q <= load_idx_d;
            i_q        <= i_d;
        end
    end

    assign data_result = result_q;
    assign overflow    = overflow_q;
    assign done        = done_q;
    assign load_idx    = load_idx_q;
    assign busy        = (state_q == S_INIT) || (state_q == S_MUL) ||
                         (state_q == S_ADD)  || (state_q == S_DONE);

endmodule

// File: tb/tb_poly_eval_horner.sv
// Directed bench for poly_eval_horner: three configurations (W8/D2, W16/D3, W8/D1)
// driven through slot loads and evaluations with hand-computed results.
module tb_poly_eval_horner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic        go_a, ovf_a, done_a, busy_a;
    logic [7:0]  din_a, res_a;
    logic [1:0]  idx_a;

    logic        go_b, ovf_b, done_b, busy_b;
    logic [15:0] din_b, res_b;
    logic [2:0]  idx_b;

    logic        go_c, ovf_c, done_c, busy_c;
    logic [7:0]  din_c, res_c;
    logic [1:0]  idx_c;

    poly_eval_horner #(.W(8), .DEGREE(2)) dut_a (
        .clk(clk), .resetn(resetn), .go(go_a), .data_in(din_a),
        .data_result(res_a), .overflow(ovf_a), .done(done_a), .busy(busy_a), .load_idx(idx_a));

    poly_eval_horner #(.W(16), .DEGREE(3)) dut_b (
        .clk(clk), .resetn(resetn), .go(go_b), .data_in(din_b),
        .data_result(res_b), .overflow(ovf_b), .done(done_b), .busy(busy_b), .load_idx(idx_b));

    poly_eval_horner #(.W(8), .DEGREE(1)) dut_c (
        .clk(clk), .resetn(resetn), .go(go_c), .data_in(din_c),
        .data_result(res_c), .overflow(ovf_c), .done(done_c), .busy(busy_c), .load_idx(idx_c));

    int checks = 0;
    int errors = 0;
    logic [15:0] vals [0:4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic g, input logic [15:0] d);
        case (sel)
            0: begin go_a = g; din_a = d[7:0]; end
            1: begin go_b = g; din_b = d;      end
            default: begin go_c = g; din_c = d[7:0]; end
        endcase
    endtask

    function automatic logic [31:0] f_res(input int sel);
        case (sel)
            0: return 32'(res_a);
            1: return 32'(res_b);
            default: return 32'(res_c);
        endcase
    endfunction

    function automatic logic [31:0] f_idx(input int sel);
        case (sel)
            0: return 32'(idx_a);
            1: return 32'(idx_b);
            default: return 32'(idx_c);
        endcase
    endfunction

    function automatic logic f_ovf(input int sel);
        case (sel)
            0: return ovf_a;
            1: return ovf_b;
            default: return ovf_c;
        endcase
    endfunction

    function automatic logic f_done(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic f_busy(input int sel);
        case (sel)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    // Loads slots 0..deg+1 from vals[]; returns with the DUT in its first S_INIT cycle.
    task automatic load_all(input int sel, input int deg, input int hold, input string tag);
        for (int k = 0; k <= deg + 1; k++) begin
            chk($sformatf("%s_idx%0d", tag, k), f_idx(sel), 32'(k));
            set_in(sel, 1'b0, vals[k]);
            @(negedge clk);
            set_in(sel, 1'b1, vals[k]);
            repeat (hold) @(negedge clk);
            set_in(sel, 1'b0, vals[k]);
            @(negedge clk);
        end
    endtask

    task automatic eval_check(input int sel, input int deg, input logic [31:0] exp_res,
                              input logic exp_ovf, input string tag);
        int n;
        chk({tag, "_busy_init"}, 32'(f_busy(sel)), 32'd1);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (f_done(sel)) break;
        end
        chk({tag, "_latency"}, 32'(n), 32'(2 * deg + 2));
        chk({tag, "_result"}, f_res(sel), exp_res);
        chk({tag, "_ovf"}, 32'(f_ovf(sel)), 32'(exp_ovf));
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(f_done(sel)), 32'd0);
        chk({tag, "_busy_low"}, 32'(f_busy(sel)), 32'd0);
        chk({tag, "_idx_zero"}, f_idx(sel), 32'd0);
    endtask

    initial begin
        int pulses;
        resetn = 1'b0;
        go_a = 1'b0; go_b = 1'b0; go_c = 1'b0;
        din_a = '0; din_b = '0; din_c = '0;
        repeat (2) @(negedge clk);
        chk("rst_res", f_res(0), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_idx", f_idx(0), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 1*16 + 2*4 + 3 = 27
        vals[0] = 16'd3; vals[1] = 16'd2; vals[2] = 16'd1; vals[3] = 16'd4;
        load_all(0, 2, 1, "s1");
        eval_check(0, 2, 32'h1B, 1'b0, "s1");

        // 16*16 overflows the multiplier
        vals[0] = 16'd0; vals[1] = 16'd0; vals[2] = 16'd16; vals[3] = 16'd16;
        load_all(0, 2, 1, "s2");
        eval_check(0, 2, 32'h00, 1'b1, "s2");

        // 200 + 100 carries out; 300 mod 256 = 44
        vals[0] = 16'd0; vals[1] = 16'd100; vals[2] = 16'd200; vals[3] = 16'd1;
        load_all(0, 2, 1, "s3");
        eval_check(0, 2, 32'h2C, 1'b1, "s3");

        // Reset mid-evaluation: no partial result, no done
        vals[0] = 16'd3; vals[1] = 16'd2; vals[2] = 16'd1; vals[3] = 16'd4;
        load_all(0, 2, 1, "rm");
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rm_res", f_res(0), 32'd0);
        chk("rm_ovf", 32'(ovf_a), 32'd0);
        chk("rm_idx", f_idx(0), 32'd0);
        chk("rm_busy", 32'(busy_a), 32'd0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (done_a) pulses++;
            @(negedge clk);
        end
        chk("rm_no_done", 32'(pulses), 32'd0);
        load_all(0, 2, 1, "rl");
        eval_check(0, 2, 32'h1B, 1'b0, "rl");

        // W16 D3, held go: 8+4+2+1 = 15
        vals[0] = 16'd1; vals[1] = 16'd1; vals[2] = 16'd1; vals[3] = 16'd1; vals[4] = 16'd2;
        load_all(1, 3, 20, "s4");
        eval_check(1, 3, 32'h000F, 1'b0, "s4");

        // D1: 3*7 + 5 = 26
        vals[0] = 16'd5; vals[1] = 16'd3; vals[2] = 16'd7;
        load_all(2, 1, 1, "s6");
        eval_check(2, 1, 32'h1A, 1'b0, "s6");

        // Same load again, toggling go while busy
        load_all(2, 1, 1, "tg");
        chk("tg_idx_busy", f_idx(2), 32'd2);
        go_c = 1'b1; @(negedge clk);
        chk("tg_idx_mul", f_idx(2), 32'd2);
        go_c = 1'b0; @(negedge clk);
        go_c = 1'b1; @(negedge clk);
        chk("tg_done", 32'(done_c), 32'd0);
        go_c = 1'b0; @(negedge clk);
        chk("tg_done_pulse", 32'(done_c), 32'd1);
        chk("tg_res", f_res(2), 32'h1A);
        repeat (3) @(negedge clk);
        chk("tg_idx_after", f_idx(2), 32'd0);
        chk("tg_res_hold", f_res(2), 32'h1A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/poly_eval_horner.md
Name: poly_eval_horner

Overview:
- Parametrised polynomial evaluator: computes y = c_N*x^N + ... + c_1*x + c_0, with N = DEGREE, using Horner's method on one shared multiply/add ALU.
- Coefficients and x are entered serially from switches with a press/release go handshake, as in the existing lab FSM blocks.
- Result feeds LEDR/HEX display logic in the top level.
- Generalises the fixed quadratic evaluator to any width and degree, and adds overflow, done and busy reporting.

Parameters:
- W, 8, data width of coefficients, x, accumulator and result.
- DEGREE, 2, polynomial degree N; legal range 1..14.
- IW, $clog2(DEGREE+2), width of the load index.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- go  in  1  load strobe, active-high, level (already inverted from KEY).
- data_in  in  W  value for the current load slot.
- data_result  out  W  last computed y mod 2^W.
- overflow  out  1  high if any intermediate of the last evaluation exceeded W bits.
- done  out  1  one-cycle pulse, coincident with the data_result update.
- busy  out  1  high while evaluating; go is ignored.
- load_idx  out  IW  slot currently being loaded.
  - Slots 0..DEGREE hold c_k.
  - Slot DEGREE+1 holds x.

Behaviour:
- Reset: while resetn=0 at posedge clk:
  - state <= S_LOAD, load_idx <= 0.
  - All coefficient registers, x, acc, data_result, overflow and done <= 0.
  - Reset applies in any state, including mid-evaluation; a partial result is never written.
- Storage: DEGREE+1 coefficient registers c[0..DEGREE], an x register and an acc register, all W bits wide.
- S_LOAD:
  - Every cycle, the slot addressed by load_idx <= data_in.
  - go=1 -> S_LOAD_WAIT.
- S_LOAD_WAIT:
  - No register writes.
  - Stay while go=1.
  - On go=0: if load_idx == DEGREE+1 -> S_INIT; else load_idx <= load_idx+1 and go to S_LOAD.
  - A go held for any length counts as exactly one advance.
- S_INIT: acc <= c[DEGREE], i <= DEGREE-1, ovf <= 0; -> S_MUL.
- S_MUL:
  - Full 2W-bit product p = acc*x.
  - acc <= p[W-1:0]; ovf <= ovf | (p[2W-1:W] != 0).
  - -> S_ADD.
- S_ADD:
  - (W+1)-bit sum s = acc + c[i].
  - acc <= s[W-1:0]; ovf <= ovf | s[W].
  - If i==0 -> S_DONE; else i <= i-1 and go to S_MUL.
- S_DONE:
  - data_result <= acc, overflow <= ovf, done <= 1 (registered, high for exactly the next cycle).
  - load_idx <= 0; -> S_LOAD.
- done is 0 in every other cycle.
- busy = 1 in S_INIT, S_MUL, S_ADD and S_DONE; 0 otherwise (combinational from state).
- Latency: 2*DEGREE+2 clocks from the first cycle in S_INIT to the edge that updates data_result and raises done.
- go is ignored while busy.
  - If go is still high on return to S_LOAD, the FSM immediately enters S_LOAD_WAIT.
  - Slot 0 has then already captured data_in.
- data_result and overflow hold their values through subsequent loads until the next S_DONE.
- Coefficient registers are never modified by evaluation, so re-evaluation reloads all slots from slot 0.
- Arithmetic is unsigned, modulo 2^W.
- The unused state encoding returns to S_LOAD.

Test Plan:
- W=8, DEGREE=2; load c0=3, c1=2, c2=1, x=4 via go pulses -> data_result=0x1B, overflow=0, done high exactly one cycle, 6 clocks after S_INIT entry.
- W=8, DEGREE=2; c2=16, c1=0, c0=0, x=16 -> data_result=0x00, overflow=1 (multiply overflow).
- W=8, DEGREE=2; c2=200, c1=100, c0=0, x=1 -> data_result=0x2C, overflow=1 (add carry only).
- W=16, DEGREE=3; c0..c3=1, x=2; go held high 20 cycles per slot -> each slot advances once, data_result=0x000F, latency 8 clocks.
- Assert resetn=0 for one cycle during S_MUL of a valid run:
  - Required immediately after reset: data_result=0, overflow=0, done never pulses, load_idx=0, busy=0.
  - Then reload the first scenario's values -> data_result=0x1B.
- DEGREE=1, W=8; c0=5, c1=3, x=7 -> data_result=0x1A; then toggle go during busy -> no effect on load_idx or result.
